// File: rtl/puf_pkg.sv
// Shared constants for the PUF datapath selection primitives.
package puf_pkg;

    localparam int MUX16_SEL_W  = 4;
    localparam int MUX16_NUM_IN = 16;

endpackage : puf_pkg

// File: rtl/mux16_to_1_comb.sv
// Combinational 16:1 selector over an unpacked array of WIDTH-bit inputs.
module mux16_to_1_comb
    import puf_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0]       data_i [MUX16_NUM_IN],
    input  logic [MUX16_SEL_W-1:0] sel_i,
    output logic [WIDTH-1:0]       data_o
);

    // Every 4-bit code addresses a real entry, so no default path is needed.
    assign data_o = data_i[sel_i];

endmodule : mux16_to_1_comb

// File: rtl/mux16_to_1.sv
// 16:1 mux with optional output register; d1 is selected by sel = 0, d16 by sel = 15.
module mux16_to_1
    import puf_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       d1,
    input  logic [WIDTH-1:0]       d2,
    input  logic [WIDTH-1:0]       d3,
    input  logic [WIDTH-1:0]       d4,
    input  logic [WIDTH-1:0]       d5,
    input  logic [WIDTH-1:0]       d6,
    input  logic [WIDTH-1:0]       d7,
    input  logic [WIDTH-1:0]       d8,
    input  logic [WIDTH-1:0]       d9,
    input  logic [WIDTH-1:0]       d10,
    input  logic [WIDTH-1:0]       d11,
    input  logic [WIDTH-1:0]       d12,
    input  logic [WIDTH-1:0]       d13,
    input  logic [WIDTH-1:0]       d14,
    input  logic [WIDTH-1:0]       d15,
    input  logic [WIDTH-1:0]       d16,
    input  logic [MUX16_SEL_W-1:0] sel,
    output logic [WIDTH-1:0]       out
);

    logic [WIDTH-1:0] d_arr [MUX16_NUM_IN];
    logic [WIDTH-1:0] out_d;

    assign d_arr[0]  = d1;
    assign d_arr[1]  = d2;
    assign d_arr[2]  = d3;
    assign d_arr[3]  = d4;
    assign d_arr[4]  = d5;
    assign d_arr[5]  = d6;
    assign d_arr[6]  = d7;
    assign d_arr[7]  = d8;
    assign d_arr[8]  = d9;
    assign d_arr[9]  = d10;
    assign d_arr[10] = d11;
    assign d_arr[11] = d12;
    assign d_arr[12] = d13;
    assign d_arr[13] = d14;
    assign d_arr[14] = d15;
    assign d_arr[15] = d16;

    mux16_to_1_comb #(
        .WIDTH (WIDTH)
    ) u_sel (
        .data_i (d_arr),
        .sel_i  (sel),
        .data_o (out_d)
    );

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] out_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q <= '0;
                end else begin
                    out_q <= out_d;
                end
            end

            assign out = out_q;
        end else begin : g_comb
            // Clock and reset are intentionally dead in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign out = out_d;
        end
    endgenerate

endmodule : mux16_to_1

// File: tb/tb_mux16_to_1.sv
// Directed bench for mux16_to_1: registered 1-bit instance and combinational 8-bit instance.
module tb_mux16_to_1;

    logic        clk;
    logic        rst_n;
    logic [15:0] dvec;
    logic [3:0]  sel;
    logic        out;

    logic        clk_c;
    logic        rst_n_c;
    logic [7:0]  dc [16];
    logic [3:0]  sel_c;
    logic [7:0]  out_c;

    int n_checks;
    int n_fail;

    mux16_to_1 #(.WIDTH(1), .REG_OUT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d1  (dvec[0]),  .d2  (dvec[1]),  .d3  (dvec[2]),  .d4  (dvec[3]),
        .d5  (dvec[4]),  .d6  (dvec[5]),  .d7  (dvec[6]),  .d8  (dvec[7]),
        .d9  (dvec[8]),  .d10 (dvec[9]),  .d11 (dvec[10]), .d12 (dvec[11]),
        .d13 (dvec[12]), .d14 (dvec[13]), .d15 (dvec[14]), .d16 (dvec[15]),
        .sel   (sel),
        .out   (out)
    );

    mux16_to_1 #(.WIDTH(8), .REG_OUT(1'b0)) dut_c (
        .clk   (clk_c),
        .rst_n (rst_n_c),
        .d1  (dc[0]),  .d2  (dc[1]),  .d3  (dc[2]),  .d4  (dc[3]),
        .d5  (dc[4]),  .d6  (dc[5]),  .d7  (dc[6]),  .d8  (dc[7]),
        .d9  (dc[8]),  .d10 (dc[9]),  .d11 (dc[10]), .d12 (dc[11]),
        .d13 (dc[12]), .d14 (dc[13]), .d15 (dc[14]), .d16 (dc[15]),
        .sel   (sel_c),
        .out   (out_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        sel   = 4'd1;
        #1;
        n_checks++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_immediate: got %b expected 0", out);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %b expected 0", i, out);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_pre_edge: got %b expected 0", out);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_first_edge: got %b expected 1", out);
        end
    endtask

    task automatic test_step();
        logic prev;
        logic exp;
        prev = out;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            sel = s[3:0];
            exp = (s % 2 == 1);
            #1;
            n_checks++;
            if (out !== prev) begin
                n_fail++;
                $display("FAIL step_latency sel=%0d: got %b expected %b", s, out, prev);
            end
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                n_checks++;
                if (out !== exp) begin
                    n_fail++;
                    $display("FAIL step sel=%0d cycle %0d: got %b expected %b", s, c, out, exp);
                end
            end
            prev = exp;
        end
    endtask

    task automatic test_sweep();
        logic [15:0] exp_tab;
        exp_tab = 16'b1010_1010_1010_1010;
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            sel = s[3:0];
            @(posedge clk); #1;
            n_checks++;
            if (out !== exp_tab[s]) begin
                n_fail++;
                $display("FAIL sweep sel=%0d: got %b expected %b", s, out, exp_tab[s]);
            end
        end
    endtask

    task automatic test_data_change();
        @(negedge clk);
        sel = 4'd5;
        @(posedge clk); #1;
        n_checks++;
        if (out !== 1'b1) begin
            n_fail++;
            $display("FAIL data_sel5_initial: got %b expected 1", out);
        end
        @(negedge clk);
        dvec[5] = 1'b0;
        #1;
        n_checks++;
        if (out !== 1'b1) begin
            n_fail++;
            $display("FAIL data_change_pre_edge: got %b expected 1", out);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL data_change_post_edge: got %b expected 0", out);
        end
        @(negedge clk);
        dvec[6] = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL unselected_d7: got %b expected 0", out);
        end
        @(negedge clk);
        dvec = 16'hAAAA;
        @(posedge clk); #1;
        n_checks++;
        if (out !== 1'b1) begin
            n_fail++;
            $display("FAIL data_restore: got %b expected 1", out);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        sel = 4'd1;
        @(posedge clk); #1;
        n_checks++;
        if (out !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre: got %b expected 1", out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %b expected 0", out);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_hold: got %b expected 0", out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out !== 1'b1) begin
            n_fail++;
            $display("FAIL async_release: got %b expected 1", out);
        end
    endtask

    task automatic test_comb();
        logic [3:0] sels [4];
        logic [7:0] exps [4];
        sels[0] = 4'hA; exps[0] = 8'h1A;
        sels[1] = 4'h0; exps[1] = 8'h10;
        sels[2] = 4'hF; exps[2] = 8'h1F;
        sels[3] = 4'h3; exps[3] = 8'h13;
        for (int i = 0; i < 4; i++) begin
            sel_c = sels[i];
            #1;
            n_checks++;
            if (out_c !== exps[i]) begin
                n_fail++;
                $display("FAIL comb sel=%h: got %h expected %h", sels[i], out_c, exps[i]);
            end
        end
        rst_n_c = 1'b0;
        #1;
        n_checks++;
        if (out_c !== 8'h13) begin
            n_fail++;
            $display("FAIL comb_reset_ignored: got %h expected 13", out_c);
        end
        rst_n_c = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        dvec     = 16'hAAAA;
        sel      = 4'd0;
        rst_n    = 1'b0;
        clk_c    = 1'b0;
        rst_n_c  = 1'b1;
        sel_c    = 4'd0;
        for (int k = 0; k < 16; k++) dc[k] = 8'h10 + k[7:0];

        test_reset();
        test_step();
        test_sweep();
        test_data_change();
        test_async_reset();
        test_comb();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux16_to_1
